// File: rtl/lasernet_pkg.sv
// Shared definitions for the laser link: packet width, source encoding and
// the transmit scheduler state/debug types.
package lasernet_pkg;

  localparam int PKT_LENGTH = 288;

  localparam logic SRC_DATA = 1'b0;
  localparam logic SRC_CTRL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } sched_state_e;

  typedef struct packed {
    sched_state_e state;
    logic         busy;
    logic [7:0]   streak;
  } sched_dbg_t;

endpackage

// File: rtl/retx_timer.sv
// Go-back-n retransmit timer: counts from a data tx_done and emits a single
// expiry pulse TIMEOUT_CYCLES edges later unless cleared by an ACK first.
module retx_timer #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;
  logic          running;

  // start beats clear so an ACK coinciding with a fresh data completion re-arms
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      running <= 1'b0;
      expire  <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (start) begin
        cnt     <= '0;
        running <= 1'b1;
      end else if (clear) begin
        cnt     <= '0;
        running <= 1'b0;
      end else if (running) begin
        if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          cnt     <= '0;
          running <= 1'b0;
          expire  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/laser_tx_sched.sv
// Shares the serial_tx laser channel between data and control packets, with
// control priority, anti-starvation, an inter-packet gap and the retx timer.
module laser_tx_sched
  import lasernet_pkg::*;
#(
  parameter int GAP_CYCLES      = 1024,
  parameter int TIMEOUT_CYCLES  = 2_000_000,
  parameter int MAX_CTRL_STREAK = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  data_req,
  input  logic [PKT_LENGTH-1:0] data_pkt,
  input  logic                  ctrl_req,
  input  logic [PKT_LENGTH-1:0] ctrl_pkt,
  input  logic                  ack_in,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic [PKT_LENGTH-1:0] tx_data,
  output logic                  tx_new,
  output logic                  grant_src,
  output logic                  data_pending,
  output logic                  ctrl_pending,
  output logic                  timeout,
  output logic [7:0]            overwrite_cnt,
  output sched_dbg_t            dbg
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  // Handshake: *_req are valid-only pulses with no ready; a request that finds
  // its slot full replaces the stored packet, tx_new/tx_done pace serial_tx.
  sched_state_e          state;
  logic [GW-1:0]         gap_cnt;
  logic [7:0]            streak;
  logic [PKT_LENGTH-1:0] data_slot;
  logic [PKT_LENGTH-1:0] ctrl_slot;
  logic                  busy_q;

  logic       grant_now;
  logic       pick_data;
  logic       data_grant;
  logic       ctrl_grant;
  logic       data_ovw;
  logic       ctrl_ovw;
  logic [9:0] ovw_sum;
  logic [7:0] ovw_next;
  logic       timer_start;

  always_comb begin
    grant_now  = (state == ST_IDLE) && (data_pending || ctrl_pending);
    pick_data  = data_pending && (!ctrl_pending || (streak == 8'(MAX_CTRL_STREAK)));
    data_grant = grant_now && pick_data;
    ctrl_grant = grant_now && !pick_data;
    // A request landing on the slot being granted refills it; not an overwrite
    data_ovw   = data_req && data_pending && !data_grant;
    ctrl_ovw   = ctrl_req && ctrl_pending && !ctrl_grant;
    ovw_sum    = {2'b00, overwrite_cnt} + 10'(data_ovw) + 10'(ctrl_ovw);
    ovw_next   = (ovw_sum > 10'd255) ? 8'hFF : ovw_sum[7:0];
    timer_start = (state == ST_SEND) && tx_done && (grant_src == SRC_DATA);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      gap_cnt       <= '0;
      streak        <= '0;
      data_slot     <= '0;
      ctrl_slot     <= '0;
      data_pending  <= 1'b0;
      ctrl_pending  <= 1'b0;
      tx_data       <= '0;
      tx_new        <= 1'b0;
      grant_src     <= SRC_DATA;
      overwrite_cnt <= '0;
      busy_q        <= 1'b0;
    end else begin
      busy_q        <= tx_busy;
      tx_new        <= 1'b0;
      overwrite_cnt <= ovw_next;

      if (data_req) begin
        data_slot    <= data_pkt;
        data_pending <= 1'b1;
      end else if (data_grant) begin
        data_pending <= 1'b0;
      end

      if (ctrl_req) begin
        ctrl_slot    <= ctrl_pkt;
        ctrl_pending <= 1'b1;
      end else if (ctrl_grant) begin
        ctrl_pending <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (grant_now) begin
            state <= ST_LOAD;
            if (pick_data) begin
              tx_data   <= data_slot;
              grant_src <= SRC_DATA;
              streak    <= '0;
            end else begin
              tx_data   <= ctrl_slot;
              grant_src <= SRC_CTRL;
              if (data_pending) streak <= streak + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          tx_new <= 1'b1;
          state  <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_done) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  retx_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_retx_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (timer_start),
    .clear  (ack_in),
    .expire (timeout)
  );

  assign dbg = {state, busy_q, streak};

endmodule

// File: tb/tb_laser_tx_sched.sv
// Bench for laser_tx_sched: directed scenarios plus random traffic, checked
// every cycle against a deadline-based behavioural model of the scheduler.
module tb_laser_tx_sched;
  import lasernet_pkg::*;

  localparam int W      = PKT_LENGTH;
  localparam int G      = 4;
  localparam int T      = 50;
  localparam int M      = 2;
  localparam int TX_LAT = 20;

  logic         clk;
  logic         reset_n;
  logic         data_req, ctrl_req, ack_in, tx_busy, tx_done;
  logic [W-1:0] data_pkt, ctrl_pkt, tx_data;
  logic         tx_new, grant_src, data_pending, ctrl_pending, timeout;
  logic [7:0]   overwrite_cnt;
  sched_dbg_t   dbg;

  laser_tx_sched #(
    .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .MAX_CTRL_STREAK(M)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .data_req(data_req), .data_pkt(data_pkt),
    .ctrl_req(ctrl_req), .ctrl_pkt(ctrl_pkt),
    .ack_in(ack_in), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_data(tx_data), .tx_new(tx_new), .grant_src(grant_src),
    .data_pending(data_pending), .ctrl_pending(ctrl_pending),
    .timeout(timeout), .overwrite_cnt(overwrite_cnt), .dbg(dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural serial_tx ----------------
  int lat;
  initial begin
    tx_done = 1'b0;
    tx_busy = 1'b0;
    lat     = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        lat = 0; tx_done = 1'b0; tx_busy = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            tx_done = 1'b1;
            tx_busy = 1'b0;
          end
        end else if (tx_new) begin
          lat     = TX_LAT - 1;
          tx_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Channel is free from m_next_grant on; a grant at edge g shows tx_new after g+1.
  // After a data tx_done at edge D the timeout is due at edge D+T.
  longint       cyc = 0;
  logic [W-1:0] m_slot [2];
  logic [1:0]   m_full;
  int           m_streak, m_ovw;
  bit           m_busy, m_to, m_pick, m_data_done;
  logic         m_cur_src;
  logic [W-1:0] m_cur_pkt;
  longint       m_next_grant, m_new_due, m_deadline, m_last_done;
  logic [W:0]   exp_q[$];

  task automatic model_reset();
    m_full = '0; m_streak = 0; m_ovw = 0; m_busy = 0; m_to = 0;
    m_slot[0] = '0; m_slot[1] = '0; m_cur_src = 1'b0; m_cur_pkt = '0;
    m_next_grant = 0; m_new_due = -1; m_deadline = -1; m_last_done = 0;
    exp_q.delete();
  endtask

  initial model_reset();

  always @(posedge clk) begin
    cyc++;
    m_to = 0;
    if (!reset_n) begin
      model_reset();
    end else begin
      if (!m_busy && cyc >= m_next_grant && (m_full != 2'b00)) begin
        m_pick = m_full[0] && (!m_full[1] || m_streak == M);
        if (m_pick) begin
          m_cur_src = SRC_DATA; m_cur_pkt = m_slot[0]; m_full[0] = 1'b0; m_streak = 0;
        end else begin
          m_cur_src = SRC_CTRL; m_cur_pkt = m_slot[1]; m_full[1] = 1'b0;
          if (m_full[0]) m_streak++;
        end
        m_busy = 1; m_new_due = cyc + 1;
        exp_q.push_back({m_cur_src, m_cur_pkt});
      end
      if (data_req) begin
        if (m_full[0]) m_ovw = (m_ovw < 255) ? m_ovw + 1 : 255;
        m_slot[0] = data_pkt; m_full[0] = 1'b1;
      end
      if (ctrl_req) begin
        if (m_full[1]) m_ovw = (m_ovw < 255) ? m_ovw + 1 : 255;
        m_slot[1] = ctrl_pkt; m_full[1] = 1'b1;
      end
      m_data_done = 0;
      if (tx_done && m_busy) begin
        m_busy = 0; m_next_grant = cyc + G + 1; m_last_done = cyc;
        m_data_done = (m_cur_src == SRC_DATA);
      end
      if (m_data_done) m_deadline = cyc + T;
      else if (ack_in) m_deadline = -1;
      else if (m_deadline == cyc) begin
        m_to = 1; m_deadline = -1;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  int           n_tx_new = 0, n_timeout = 0, n_data_tx = 0;
  longint       last_gap = 0;
  logic         obs_src_q[$];
  logic [W-1:0] obs_last_data;
  logic [W:0]   e;

  always @(negedge clk) begin
    if (reset_n && cyc > 0) begin
      check_eq("tx_new", W'(tx_new), W'(cyc == m_new_due));
      if (tx_new) begin
        n_tx_new++;
        last_gap = cyc - m_last_done;
        obs_src_q.push_back(grant_src);
        if (grant_src == SRC_DATA) begin
          n_data_tx++;
          obs_last_data = tx_data;
        end
        if (exp_q.size() == 0) check_eq("tx_unexpected", W'(tx_new), W'(0));
        else begin
          e = exp_q.pop_front();
          check_eq("tx_data", tx_data, e[W-1:0]);
          check_eq("grant_src", W'(grant_src), W'(e[W]));
        end
      end
      if (m_busy) check_eq("tx_data_hold", tx_data, m_cur_pkt);
      if (timeout) n_timeout++;
      check_eq("timeout", W'(timeout), W'(m_to));
      check_eq("data_pending", W'(data_pending), W'(m_full[0]));
      check_eq("ctrl_pending", W'(ctrl_pending), W'(m_full[1]));
      check_eq("overwrite_cnt", W'(overwrite_cnt), W'(m_ovw));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_pkt();
    logic [W-1:0] p;
    for (int i = 0; i < W / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input bit d, input bit c, input logic [W-1:0] dp, input logic [W-1:0] cp);
    data_req = d; ctrl_req = c; data_pkt = dp; ctrl_pkt = cp;
    @(negedge clk);
    data_req = 1'b0; ctrl_req = 1'b0;
  endtask

  task automatic ack_pulse();
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      if (tx_done) seen = 1;
    end
    check_eq(tag, W'(seen), W'(1));
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_tx_new"}, W'(tx_new), W'(0));
    check_eq({tag, "_timeout"}, W'(timeout), W'(0));
    check_eq({tag, "_data_pending"}, W'(data_pending), W'(0));
    check_eq({tag, "_ctrl_pending"}, W'(ctrl_pending), W'(0));
    check_eq({tag, "_grant_src"}, W'(grant_src), W'(0));
    check_eq({tag, "_tx_data"}, tx_data, W'(0));
    check_eq({tag, "_overwrite_cnt"}, W'(overwrite_cnt), W'(0));
    check_eq({tag, "_state"}, W'(dbg.state), W'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] pkt_a5, pkt_b;
  int           n0, to0;

  initial begin
    reset_n = 1'b0; data_req = 1'b0; ctrl_req = 1'b0; ack_in = 1'b0;
    data_pkt = '0; ctrl_pkt = '0;
    idle(3);
    check_reset_vals("rst");
    reset_n = 1'b1;
    idle(2);

    // 1: single data packet, tx_new two cycles after pending
    pkt_a5 = {36{8'hA5}};
    pulse_req(1, 0, pkt_a5, '0);
    check_eq("t1_pending", W'(data_pending), W'(1));
    idle(1);
    check_eq("t1_pending_clr", W'(data_pending), W'(0));
    check_eq("t1_no_new_yet", W'(tx_new), W'(0));
    idle(1);
    check_eq("t1_tx_new", W'(tx_new), W'(1));
    check_eq("t1_tx_data", tx_data, pkt_a5);
    check_eq("t1_src", W'(grant_src), W'(SRC_DATA));
    idle(40);

    // 2: simultaneous requests, ctrl first, gap before data
    obs_src_q.delete();
    pulse_req(1, 1, rand_pkt(), rand_pkt());
    idle(80);
    check_eq("t2_count", W'(obs_src_q.size()), W'(2));
    if (obs_src_q.size() == 2) begin
      check_eq("t2_first", W'(obs_src_q[0]), W'(SRC_CTRL));
      check_eq("t2_second", W'(obs_src_q[1]), W'(SRC_DATA));
    end
    check_eq("t2_gap", W'(last_gap), W'(G + 2));

    // 3: anti-starvation with MAX_CTRL_STREAK=2
    obs_src_q.delete();
    pulse_req(1, 1, rand_pkt(), rand_pkt());
    idle(5);
    pulse_req(0, 1, '0, rand_pkt());
    idle(30);
    pulse_req(0, 1, '0, rand_pkt());
    idle(120);
    check_eq("t3_count", W'(obs_src_q.size()), W'(4));
    if (obs_src_q.size() == 4) begin
      check_eq("t3_g0", W'(obs_src_q[0]), W'(SRC_CTRL));
      check_eq("t3_g1", W'(obs_src_q[1]), W'(SRC_CTRL));
      check_eq("t3_g2", W'(obs_src_q[2]), W'(SRC_DATA));
      check_eq("t3_g3", W'(obs_src_q[3]), W'(SRC_CTRL));
    end

    // 4: overwrite while busy
    n0 = n_data_tx;
    pkt_b = rand_pkt();
    pulse_req(0, 1, '0, rand_pkt());
    idle(5);
    pulse_req(1, 0, rand_pkt(), '0);
    idle(3);
    pulse_req(1, 0, pkt_b, '0);
    check_eq("t4_overwrite", W'(overwrite_cnt), W'(1));
    idle(70);
    check_eq("t4_data_sent", W'(n_data_tx - n0), W'(1));
    check_eq("t4_pkt", obs_last_data, pkt_b);

    // 5: retransmit timer
    ack_pulse();
    idle(2);
    to0 = n_timeout;
    pulse_req(1, 0, rand_pkt(), '0);
    wait_done("t5a_done_seen");
    idle(70);
    check_eq("t5a_timeouts", W'(n_timeout - to0), W'(1));

    to0 = n_timeout;
    pulse_req(1, 0, rand_pkt(), '0);
    wait_done("t5b_done_seen");
    idle(48);
    ack_pulse();
    idle(30);
    check_eq("t5b_timeouts", W'(n_timeout - to0), W'(0));

    to0 = n_timeout;
    pulse_req(1, 0, rand_pkt(), '0);
    wait_done("t5c_done_seen");
    idle(49);
    ack_pulse();
    idle(30);
    check_eq("t5c_timeouts", W'(n_timeout - to0), W'(0));

    // 6: reset during SEND
    pulse_req(0, 1, '0, rand_pkt());
    idle(10);
    reset_n = 1'b0;
    idle(1);
    check_reset_vals("t6_rst");
    idle(2);
    reset_n = 1'b1;
    idle(2);
    n0 = n_tx_new;
    pulse_req(0, 1, '0, rand_pkt());
    idle(40);
    check_eq("t6_sent", W'(n_tx_new - n0), W'(1));
    if (obs_src_q.size() > 0) check_eq("t6_src", W'(obs_src_q[$]), W'(SRC_CTRL));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      data_req = ($urandom_range(0, 39) == 0);
      ctrl_req = ($urandom_range(0, 29) == 0);
      ack_in   = ($urandom_range(0, 59) == 0);
      data_pkt = rand_pkt();
      ctrl_pkt = rand_pkt();
      @(negedge clk);
    end
    data_req = 1'b0; ctrl_req = 1'b0; ack_in = 1'b0;
    idle(150);
    check_eq("end_queue_empty", W'(exp_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
